// File: rtl/host_cycle_ctrl.sv
// 65816 clock generator and host (BBC) bus cycle sequencer.
// Runs cpu_phi2 from hsclk in fast mode and stretches it onto the host phi0 for host accesses.
module host_cycle_ctrl #(
    parameter int FAST_HALF   = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic hsclk_i,
    input  logic reset_i,
    input  logic bbc_phi0_i,
    input  logic bbc_rdy_i,
    input  logic host_req_i,
    input  logic cpu_rnw_i,
    output logic cpu_phi2_o,
    output logic lat_en_o,
    output logic bbc_rnw_o,
    output logic bbc_d_oe_o,
    output logic rd_capture_o,
    output logic host_active_o
);

    localparam int CNT_W = (FAST_HALF > 1) ? $clog2(FAST_HALF) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FAST_HALF - 1);

    typedef enum logic [1:0] {
        FAST      = 2'd0,
        WAIT_FALL = 2'd1,
        HOST_PH1  = 2'd2,
        HOST_PH2  = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [SYNC_STAGES-1:0] phi0_sync_q;
    logic [SYNC_STAGES-1:0] rdy_sync_q;
    logic                   phi0_d_q;
    logic                   rnw_q, rnw_d;
    logic                   cpu_phi2_q, cpu_phi2_d;
    logic                   lat_en_q, lat_en_d;
    logic                   bbc_rnw_q, bbc_rnw_d;
    logic                   bbc_d_oe_q, bbc_d_oe_d;
    logic                   rd_capture_q, rd_capture_d;
    logic                   host_active_q, host_active_d;

    logic phi0_s, rdy_s, rise, fall;

    assign phi0_s = phi0_sync_q[SYNC_STAGES-1];
    assign rdy_s  = rdy_sync_q[SYNC_STAGES-1];
    assign rise   = phi0_s & ~phi0_d_q;
    assign fall   = ~phi0_s & phi0_d_q;

    always_ff @(posedge hsclk_i) begin
        if (reset_i) begin
            state_q       <= FAST;
            cnt_q         <= '0;
            phi0_sync_q   <= '0;
            rdy_sync_q    <= '0;
            phi0_d_q      <= 1'b0;
            rnw_q         <= 1'b1;
            cpu_phi2_q    <= 1'b0;
            lat_en_q      <= 1'b0;
            bbc_rnw_q     <= 1'b1;
            bbc_d_oe_q    <= 1'b0;
            rd_capture_q  <= 1'b0;
            host_active_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            phi0_sync_q   <= {phi0_sync_q[SYNC_STAGES-2:0], bbc_phi0_i};
            rdy_sync_q    <= {rdy_sync_q[SYNC_STAGES-2:0], bbc_rdy_i};
            phi0_d_q      <= phi0_s;
            rnw_q         <= rnw_d;
            cpu_phi2_q    <= cpu_phi2_d;
            lat_en_q      <= lat_en_d;
            bbc_rnw_q     <= bbc_rnw_d;
            bbc_d_oe_q    <= bbc_d_oe_d;
            rd_capture_q  <= rd_capture_d;
            host_active_q <= host_active_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        rnw_d         = rnw_q;
        cpu_phi2_d    = cpu_phi2_q;
        lat_en_d      = lat_en_q;
        bbc_rnw_d     = bbc_rnw_q;
        bbc_d_oe_d    = bbc_d_oe_q;
        rd_capture_d  = 1'b0;
        host_active_d = host_active_q;

        case (state_q)
            FAST: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (!cpu_phi2_q && host_req_i) begin
                        rnw_d         = cpu_rnw_i;
                        host_active_d = 1'b1;
                        // a phi0 fall coinciding with acceptance must not be lost
                        if (fall) begin
                            state_d   = HOST_PH1;
                            lat_en_d  = 1'b1;
                            bbc_rnw_d = cpu_rnw_i;
                        end else begin
                            state_d = WAIT_FALL;
                        end
                    end else begin
                        cpu_phi2_d = ~cpu_phi2_q;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT_FALL: begin
                if (fall) begin
                    state_d   = HOST_PH1;
                    lat_en_d  = 1'b1;
                    bbc_rnw_d = rnw_q;
                end
            end
            HOST_PH1: begin
                if (rise) begin
                    state_d    = HOST_PH2;
                    lat_en_d   = 1'b0;
                    cpu_phi2_d = 1'b1;
                    bbc_d_oe_d = ~rnw_q;
                end
            end
            HOST_PH2: begin
                if (fall) begin
                    if (!rnw_q || rdy_s) begin
                        state_d       = FAST;
                        cnt_d         = '0;
                        cpu_phi2_d    = 1'b0;
                        bbc_d_oe_d    = 1'b0;
                        bbc_rnw_d     = 1'b1;
                        host_active_d = 1'b0;
                        rd_capture_d  = rnw_q;
                    end else begin
                        // host RDY low: keep the CPU frozen in phi2 for another host cycle
                        state_d    = HOST_PH1;
                        lat_en_d   = 1'b1;
                        bbc_d_oe_d = 1'b0;
                    end
                end
            end
            default: state_d = FAST;
        endcase
    end

    assign cpu_phi2_o    = cpu_phi2_q;
    assign lat_en_o      = lat_en_q;
    assign bbc_rnw_o     = bbc_rnw_q;
    assign bbc_d_oe_o    = bbc_d_oe_q;
    assign rd_capture_o  = rd_capture_q;
    assign host_active_o = host_active_q;

endmodule

// File: tb/tb_host_cycle_ctrl.sv
// Self-checking bench for host_cycle_ctrl: directed host-cycle scenarios plus randomized traffic,
// all outputs compared every cycle against a phase/transaction-level reference model.
`timescale 1ns/1ps
module tb_host_cycle_ctrl;
    localparam int FH = 2;
    localparam int SS = 2;
    localparam int H_NONE = 0, H_WAIT = 1, H_ADDR = 2, H_DATA = 3;

    logic hsclk = 1'b0;
    logic reset, phi0, rdy, req, rnw_in;
    logic cpu_phi2, lat_en, bbc_rnw, bbc_d_oe, rd_capture, host_active;

    host_cycle_ctrl #(.FAST_HALF(FH), .SYNC_STAGES(SS)) dut (
        .hsclk_i      (hsclk),
        .reset_i      (reset),
        .bbc_phi0_i   (phi0),
        .bbc_rdy_i    (rdy),
        .host_req_i   (req),
        .cpu_rnw_i    (rnw_in),
        .cpu_phi2_o   (cpu_phi2),
        .lat_en_o     (lat_en),
        .bbc_rnw_o    (bbc_rnw),
        .bbc_d_oe_o   (bbc_d_oe),
        .rd_capture_o (rd_capture),
        .host_active_o(host_active)
    );

    always #5 hsclk = ~hsclk;

    int checks = 0;
    int errors = 0;

    // reference model: fast clock as a position within its period, host access as a step
    int m_step = H_NONE;
    int m_pos  = 0;
    bit m_rnw  = 1'b1;
    bit m_held = 1'b0;
    bit m_cap  = 1'b0;
    bit m_p0 [0:SS];
    bit m_rd [0:SS-1];

    int ph_cnt = 0, ph_half = 4, ph_lo = 4, ph_hi = 4;
    int ecnt = 0, rise_e = 0;
    int cap_cnt = 0, fall_in_host = 0, active_cnt = 0, hi_cnt = 0, lat_cnt = 0;
    logic prev_phi2 = 1'b0;

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0b expected %0b (edge %0d)", tag, obs, exp, ecnt);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_le(input string tag, input int obs, input int lim);
        checks++;
        assert (obs <= lim) else begin
            errors++;
            $error("FAIL %s: observed %0d expected at most %0d", tag, obs, lim);
        end
    endtask

    function automatic logic e_phi2();
        case (m_step)
            H_NONE:  return logic'(m_pos >= FH);
            H_WAIT:  return 1'b0;
            H_ADDR:  return m_held;
            default: return 1'b1;
        endcase
    endfunction

    task automatic model_step();
        bit rise_s, fall_s, rdy_s;
        rise_s = m_p0[SS-1] && !m_p0[SS];
        fall_s = !m_p0[SS-1] && m_p0[SS];
        rdy_s  = m_rd[SS-1];
        m_cap  = 1'b0;
        if (reset) begin
            m_step = H_NONE;
            m_pos  = 0;
            m_held = 1'b0;
            m_rnw  = 1'b1;
            foreach (m_p0[i]) m_p0[i] = 1'b0;
            foreach (m_rd[i]) m_rd[i] = 1'b0;
            return;
        end
        for (int i = SS; i > 0; i--) m_p0[i] = m_p0[i-1];
        m_p0[0] = phi0;
        for (int i = SS - 1; i > 0; i--) m_rd[i] = m_rd[i-1];
        m_rd[0] = rdy;
        case (m_step)
            H_NONE: begin
                if (m_pos == FH - 1 && req) begin
                    m_rnw  = rnw_in;
                    m_held = 1'b0;
                    m_step = fall_s ? H_ADDR : H_WAIT;
                end else begin
                    m_pos = (m_pos + 1) % (2 * FH);
                end
            end
            H_WAIT: if (fall_s) begin m_step = H_ADDR; m_held = 1'b0; end
            H_ADDR: if (rise_s) m_step = H_DATA;
            default: begin
                if (fall_s) begin
                    if (!m_rnw || rdy_s) begin
                        m_cap  = m_rnw;
                        m_step = H_NONE;
                        m_pos  = 0;
                    end else begin
                        m_step = H_ADDR;
                        m_held = 1'b1;
                    end
                end
            end
        endcase
    endtask

    task automatic tick();
        model_step();
        @(posedge hsclk);
        #1;
        ecnt++;
        chk("cpu_phi2", cpu_phi2, e_phi2());
        chk("lat_en", lat_en, logic'(m_step == H_ADDR));
        chk("bbc_rnw", bbc_rnw, (m_step == H_ADDR || m_step == H_DATA) ? m_rnw : 1'b1);
        chk("bbc_d_oe", bbc_d_oe, logic'(m_step == H_DATA && !m_rnw));
        chk("rd_capture", rd_capture, m_cap);
        chk("host_active", host_active, logic'(m_step != H_NONE));
        chk("lat_oe_excl", lat_en & bbc_d_oe, 1'b0);
        if (rd_capture) cap_cnt++;
        if (host_active) active_cnt++;
        if (cpu_phi2) hi_cnt++;
        if (lat_en) lat_cnt++;
        if (prev_phi2 && !cpu_phi2 && host_active) fall_in_host++;
        if (!prev_phi2 && cpu_phi2 && host_active) chk_le("host_latency", ecnt - rise_e, SS + 1);
        prev_phi2 = cpu_phi2;
        ph_cnt++;
        if (ph_cnt >= ph_half) begin
            ph_cnt = 0;
            phi0 = ~phi0;
            if (phi0) rise_e = ecnt;
            ph_half = $urandom_range(ph_hi, ph_lo);
        end
    endtask

    task automatic wait_accept(input int bound);
        int n = 0;
        while (m_step == H_NONE && n < bound) begin tick(); n++; end
        req = 1'b0;
        chk("accept_seen", host_active, 1'b1);
    endtask

    task automatic run_until_idle(input int bound);
        int n = 0;
        while (m_step != H_NONE && n < bound) begin tick(); n++; end
        chk("idle_reached", host_active, 1'b0);
    endtask

    task automatic wait_phi0_high_mid(input int bound);
        int n = 0;
        while (!(phi0 && ph_cnt == 1) && n < bound) begin tick(); n++; end
    endtask

    initial begin
        int n;
        bit found;
        reset = 1'b1; phi0 = 1'b0; rdy = 1'b1; req = 1'b0; rnw_in = 1'b1;
        repeat (3) tick();
        chk("rst_cpu_phi2", cpu_phi2, 1'b0);
        chk("rst_bbc_rnw", bbc_rnw, 1'b1);
        chk("rst_host_active", host_active, 1'b0);
        reset = 1'b0;

        // 1: fast mode only
        hi_cnt = 0; lat_cnt = 0; active_cnt = 0;
        repeat (20) tick();
        chk_int("fast_duty", hi_cnt, 10);
        chk_int("fast_lat_en", lat_cnt, 0);
        chk_int("fast_active", active_cnt, 0);

        // 2: read issued mid phi0-high
        wait_phi0_high_mid(40);
        cap_cnt = 0; lat_cnt = 0;
        req = 1'b1; rnw_in = 1'b1;
        wait_accept(20);
        run_until_idle(60);
        chk_int("read_captures", cap_cnt, 1);
        chk_le("read_lat_en_cycles", 1, lat_cnt);
        repeat (6) tick();

        // 3: write
        cap_cnt = 0;
        req = 1'b1; rnw_in = 1'b0;
        wait_accept(20);
        run_until_idle(60);
        chk_int("write_captures", cap_cnt, 0);
        chk("write_rnw_restored", bbc_rnw, 1'b1);
        repeat (6) tick();

        // 4: read stretched by RDY low for two host cycles
        cap_cnt = 0; fall_in_host = 0;
        req = 1'b1; rnw_in = 1'b1;
        wait_accept(20);
        rdy = 1'b0;
        n = 0;
        while (m_step != H_DATA && n < 40) begin tick(); n++; end
        repeat (16) tick();
        chk_int("stall_no_capture", cap_cnt, 0);
        chk("stall_phi2_high", cpu_phi2, 1'b1);
        rdy = 1'b1;
        run_until_idle(60);
        chk_int("stall_captures", cap_cnt, 1);
        chk_int("stall_phi2_no_drop", fall_in_host, 0);
        repeat (6) tick();

        // 5: request coinciding with the synchronised phi0 fall
        ph_lo = 4; ph_hi = 5;
        found = 1'b0; n = 0;
        while (!found && n < 600) begin
            if (m_step == H_NONE && m_pos == FH - 1 && !m_p0[SS-1] && m_p0[SS]) begin
                req = 1'b1; rnw_in = 1'b1;
                tick();
                req = 1'b0;
                found = 1'b1;
                chk("fall_accept_lat_en", lat_en, 1'b1);
                chk("fall_accept_active", host_active, 1'b1);
            end else begin
                tick();
            end
            n++;
        end
        chk("fall_alignment_found", found, 1'b1);
        cap_cnt = 0; active_cnt = 0;
        run_until_idle(60);
        chk_int("fall_accept_captures", cap_cnt, 1);
        chk_le("fall_accept_span", active_cnt, 12);
        ph_lo = 4; ph_hi = 4;
        repeat (6) tick();

        // 6: reset during HOST_PH2 of a read
        cap_cnt = 0;
        req = 1'b1; rnw_in = 1'b1;
        wait_accept(20);
        n = 0;
        while (m_step != H_DATA && n < 40) begin tick(); n++; end
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_mid_capture", rd_capture, 1'b0);
        chk("rst_mid_active", host_active, 1'b0);
        chk("rst_mid_phi2", cpu_phi2, 1'b0);
        chk("rst_mid_rnw", bbc_rnw, 1'b1);
        hi_cnt = 0;
        repeat (12) tick();
        chk_int("rst_mid_fast_resume", hi_cnt, 6);
        chk_int("rst_mid_no_capture", cap_cnt, 0);

        // randomized traffic
        ph_lo = 3; ph_hi = 6;
        for (int k = 0; k < 3000; k++) begin
            req    = ($urandom_range(3, 0) == 0);
            rnw_in = 1'($urandom_range(1, 0));
            if ($urandom_range(15, 0) == 0) rdy = ~rdy;
            reset  = ($urandom_range(499, 0) == 0);
            tick();
        end
        reset = 1'b0; rdy = 1'b1; req = 1'b0;
        run_until_idle(100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
